eeprom_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer in front of the serial EEPROM read/write engine. It takes one byte-level read or write request at a time from each of two clients and issues it to the engine as a single-cycle WR/RD command. It holds address and write data stable until the engine's ACK, captures read data, and returns a per-client DONE or ERR. It sits between the system-side clients and the EEPROM engine, so the engine never sees overlapping commands.

---
 rtl/eeprom_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/eeprom_arbiter.sv | 150 +++++++++++++++
 tb/tb_eeprom_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eeprom_pkg.sv
// Shared EEPROM types: sequencer states, bus widths and the latched command record.
// Used by both the arbiter and the serial engine so the widths stay in lockstep.
package eeprom_pkg;

    localparam int EE_ADDR_W = 11;
    localparam int EE_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_DONE,
        ST_ABORT
    } state_t;

    typedef struct packed {
        logic                 we;
        logic [EE_ADDR_W-1:0] addr;
        logic [EE_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant, combinational in the request; ties go to the client that was not served last.
// The last-served index only moves on i_upd, i.e. when a transaction completes or aborts.
module rr_arb2 (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_upd_idx,
    output logic       o_vld,
    output logic       o_gnt_idx
);

    logic r_last_gnt;

    // Reset to 1 so client 0 wins the very first tie.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_last_gnt <= 1'b1;
        end else if (i_upd) begin
            r_last_gnt <= i_upd_idx;
        end
    end

    always_comb begin
        o_vld     = |i_req;
        o_gnt_idx = 1'b0;
        if (i_req == 2'b11) begin
            o_gnt_idx = ~r_last_gnt;
        end else if (i_req[1]) begin
            o_gnt_idx = 1'b1;
        end
    end

endmodule

// File: rtl/eeprom_arbiter.sv
// Serialises byte requests from two clients onto the EEPROM engine: one command in flight, held until ACK or timeout.
// Command pulse one cycle after REQ is seen in IDLE; DONE/ERR one cycle after ACK/timeout; clients hold REQ until then.
module eeprom_arbiter
    import eeprom_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 i_req0,
    input  logic                 i_req1,
    input  logic                 i_we0,
    input  logic                 i_we1,
    input  logic [EE_ADDR_W-1:0] i_addr0,
    input  logic [EE_ADDR_W-1:0] i_addr1,
    input  logic [EE_DATA_W-1:0] i_wdata0,
    input  logic [EE_DATA_W-1:0] i_wdata1,
    output logic                 o_done0,
    output logic                 o_done1,
    output logic                 o_err0,
    output logic                 o_err1,
    output logic [EE_DATA_W-1:0] o_rdata,
    output logic                 o_busy,
    output logic                 o_e_wr,
    output logic                 o_e_rd,
    output logic [EE_ADDR_W-1:0] o_e_addr,
    inout  wire  [EE_DATA_W-1:0] io_e_data,
    input  logic                 i_e_ack,
    output logic                 o_e_reset
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    cmd_t                 r_cmd;
    cmd_t                 w_cmd_sel;
    logic                 r_gnt;
    logic [CNT_W-1:0]     r_cnt;
    logic [EE_DATA_W-1:0] r_rdata;
    logic                 w_arb_vld;
    logic                 w_arb_gnt;
    logic                 w_arb_upd;
    logic                 w_drive;

    rr_arb2 u_rr_arb2 (
        .CLK       (CLK),
        .RESET     (RESET),
        .i_req     ({i_req1, i_req0}),
        .i_upd     (w_arb_upd),
        .i_upd_idx (r_gnt),
        .o_vld     (w_arb_vld),
        .o_gnt_idx (w_arb_gnt)
    );

    always_comb begin
        if (w_arb_gnt) begin
            w_cmd_sel = '{we: i_we1, addr: i_addr1, wdata: i_wdata1};
        end else begin
            w_cmd_sel = '{we: i_we0, addr: i_addr0, wdata: i_wdata0};
        end
    end

    // Command registers load only on IDLE exit, so client inputs are ignored mid-transaction.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_gnt   <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_vld) begin
                        r_gnt <= w_arb_gnt;
                        r_cmd <= w_cmd_sel;
                    end
                end
                ST_ISSUE: r_cnt <= '0;
                ST_WAIT_ACK: begin
                    if (i_e_ack) begin
                        if (!r_cmd.we) begin
                            r_rdata <= io_e_data;
                        end
                    end else if (r_cnt != CNT_TC) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_arb_upd   = 1'b0;
        w_drive     = 1'b0;
        o_e_wr      = 1'b0;
        o_e_rd      = 1'b0;
        o_done0     = 1'b0;
        o_done1     = 1'b0;
        o_err0      = 1'b0;
        o_err1      = 1'b0;
        o_e_reset   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_vld) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_e_wr      = r_cmd.we;
                o_e_rd      = ~r_cmd.we;
                w_drive     = r_cmd.we;
                w_state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                w_drive = r_cmd.we;
                if (i_e_ack) begin
                    w_arb_upd   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == CNT_TC) begin
                    w_state_nxt = ST_ABORT;
                end
            end
            ST_DONE: begin
                o_done0     = ~r_gnt;
                o_done1     = r_gnt;
                w_state_nxt = ST_IDLE;
            end
            ST_ABORT: begin
                o_err0      = ~r_gnt;
                o_err1      = r_gnt;
                o_e_reset   = 1'b1;
                w_arb_upd   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_busy    = (r_state != ST_IDLE);
    assign o_rdata   = r_rdata;
    assign o_e_addr  = r_cmd.addr;
    assign io_e_data = w_drive ? r_cmd.wdata : {EE_DATA_W{1'bz}};

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Directed bench: a table of single-client transactions plus hand-written arbitration, timeout and reset sequences.
// A second instance with a 16-cycle timeout and a silent engine covers the abort path.
`timescale 1ns/1ps
module tb_eeprom_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [10:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        done0, done1, err0, err1, busy, e_wr, e_rd, e_reset;
    logic [7:0]  rdata;
    logic [10:0] e_addr;
    logic        e_ack;
    wire  [7:0]  e_data;
    logic        tb_den;
    logic [7:0]  tb_dval;

    logic        rst_b, reqb0, reqb1, ackb;
    logic        doneb0, doneb1, errb0, errb1, busy_b, e_wr_b, e_rd_b, e_reset_b;
    logic [7:0]  rdata_b;
    logic [10:0] e_addr_b;
    wire  [7:0]  e_data_b;

    int n_chk = 0;
    int n_err = 0;

    assign e_data = tb_den ? tb_dval : 8'hzz;

    eeprom_arbiter u_dut (
        .CLK(clk), .RESET(rst),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_done0(done0), .o_done1(done1), .o_err0(err0), .o_err1(err1),
        .o_rdata(rdata), .o_busy(busy), .o_e_wr(e_wr), .o_e_rd(e_rd),
        .o_e_addr(e_addr), .io_e_data(e_data), .i_e_ack(e_ack), .o_e_reset(e_reset)
    );

    eeprom_arbiter #(.TIMEOUT_CYCLES(16)) u_dut_to (
        .CLK(clk), .RESET(rst_b),
        .i_req0(reqb0), .i_req1(reqb1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_done0(doneb0), .o_done1(doneb1), .o_err0(errb0), .o_err1(errb1),
        .o_rdata(rdata_b), .o_busy(busy_b), .o_e_wr(e_wr_b), .o_e_rd(e_rd_b),
        .o_e_addr(e_addr_b), .io_e_data(e_data_b), .i_e_ack(ackb), .o_e_reset(e_reset_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic       we;
        logic [10:0] addr;
        logic [7:0] wd;
        int         dly;
        logic [7:0] ackd;
        logic [7:0] exp_rdata;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Waits up to 8 negedges for a command pulse on the main instance; returns edges waited.
    task automatic wait_cmd(output int k);
        for (k = 0; k < 8; k++) begin
            @(negedge clk);
            if (e_wr | e_rd) break;
        end
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int k;
        int extra;
        if (v.c == 0) begin
            we0 = v.we; addr0 = v.addr; wdata0 = v.wd; req0 = 1'b1;
        end else begin
            we1 = v.we; addr1 = v.addr; wdata1 = v.wd; req1 = 1'b1;
        end
        wait_cmd(k);
        chk($sformatf("v%0d_cmd_lat", idx), k, 0);
        chk($sformatf("v%0d_e_wr", idx), e_wr, v.we);
        chk($sformatf("v%0d_e_rd", idx), e_rd, !v.we);
        chk($sformatf("v%0d_e_addr", idx), e_addr, v.addr);
        @(negedge clk);
        chk($sformatf("v%0d_pulse_once", idx), e_wr | e_rd, 0);
        chk($sformatf("v%0d_busy", idx), busy, 1);
        if (v.we) chk($sformatf("v%0d_e_data_drv", idx), e_data, v.wd);
        else      chk($sformatf("v%0d_e_data_hiz", idx), (e_data !== v.wd), 1);
        extra = 0;
        repeat (v.dly) begin
            @(negedge clk);
            if (done0 | done1 | err0 | err1) extra++;
        end
        chk($sformatf("v%0d_early_done", idx), extra, 0);
        e_ack = 1'b1; tb_den = !v.we; tb_dval = v.ackd;
        @(negedge clk);
        e_ack = 1'b0; tb_den = 1'b0;
        chk($sformatf("v%0d_done", idx), {done1, done0}, (v.c == 1) ? 2'b10 : 2'b01);
        chk($sformatf("v%0d_err", idx), {err1, err0}, 2'b00);
        chk($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_done_1cyc", idx), {done1, done0}, 2'b00);
        chk($sformatf("v%0d_idle", idx), busy, 0);
    endtask

    vec_t vecs[5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n, bad;
        logic exp_c;
        rst = 1'b1; rst_b = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        e_ack = 0; tb_den = 0; tb_dval = '0;
        reqb0 = 0; reqb1 = 0; ackb = 0;

        vecs[0] = '{c: 0, we: 1'b1, addr: 11'h123, wd: 8'hA5, dly: 40, ackd: 8'h00, exp_rdata: 8'h00};
        vecs[1] = '{c: 1, we: 1'b0, addr: 11'h7FF, wd: 8'hC3, dly: 5,  ackd: 8'h3C, exp_rdata: 8'h3C};
        vecs[2] = '{c: 0, we: 1'b0, addr: 11'h001, wd: 8'h99, dly: 0,  ackd: 8'h5A, exp_rdata: 8'h5A};
        vecs[3] = '{c: 1, we: 1'b1, addr: 11'h400, wd: 8'h81, dly: 3,  ackd: 8'h00, exp_rdata: 8'h5A};
        vecs[4] = '{c: 0, we: 1'b0, addr: 11'h2AA, wd: 8'h11, dly: 1,  ackd: 8'hFF, exp_rdata: 8'hFF};

        repeat (3) @(negedge clk);
        rst = 1'b0; rst_b = 1'b0;
        chk("rst_outs", {done0, done1, err0, err1, e_wr, e_rd, e_reset, busy}, 8'h00);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_e_addr", e_addr, 11'h000);
        chk("rst_b_outs", {doneb0, errb0, e_wr_b, e_reset_b, busy_b}, 5'h00);
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_txn(vecs[i], i);

        // Spurious ACK in IDLE, then client inputs changing while the command is in flight.
        e_ack = 1'b1;
        @(negedge clk);
        e_ack = 1'b0;
        chk("spur_no_done", {done1, done0, busy}, 3'b000);
        @(negedge clk);
        chk("spur_no_done2", {done1, done0, busy}, 3'b000);
        we0 = 1'b1; addr0 = 11'h055; wdata0 = 8'hE7; req0 = 1'b1;
        wait_cmd(k);
        chk("mid_cmd_lat", k, 0);
        addr0 = 11'h6AA; we0 = 1'b0; wdata0 = 8'h18;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (e_addr !== 11'h055 || e_data !== 8'hE7 || done0 || done1) bad++;
        end
        chk("mid_hold", bad, 0);
        e_ack = 1'b1;
        @(negedge clk);
        e_ack = 1'b0;
        chk("mid_done", {done1, done0}, 2'b01);
        chk("mid_addr_in_done", e_addr, 11'h055);
        chk("mid_rdata_kept", rdata, 8'hFF);
        req0 = 1'b0;
        @(negedge clk);

        // Reset while a read waits for its ACK.
        we1 = 1'b0; addr1 = 11'h0F0; wdata1 = 8'h96; req1 = 1'b1;
        wait_cmd(k);
        chk("rstw_e_rd", e_rd, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1; req1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_busy", busy, 0);
        chk("rstw_rdata", rdata, 8'h00);
        chk("rstw_e_addr", e_addr, 11'h000);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (done0 | done1 | err0 | err1 | busy) bad++;
        end
        chk("rstw_quiet", bad, 0);

        // Both clients from reset, each re-requesting right after its DONE.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        we0 = 1'b1; we1 = 1'b1; addr0 = 11'h010; addr1 = 11'h020;
        wdata0 = 8'h11; wdata1 = 8'h22; req0 = 1'b1; req1 = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_c = t[0];
            wait_cmd(k);
            chk($sformatf("arb%0d_lat", t), k, 0);
            chk($sformatf("arb%0d_addr", t), e_addr, exp_c ? 11'h020 : 11'h010);
            @(negedge clk);
            e_ack = 1'b1;
            @(negedge clk);
            e_ack = 1'b0;
            chk($sformatf("arb%0d_done", t), {done1, done0}, exp_c ? 2'b10 : 2'b01);
            if (t == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end else begin
                if (exp_c) req1 = 1'b0; else req0 = 1'b0;
                @(negedge clk);
                if (exp_c) req1 = 1'b1; else req0 = 1'b1;
            end
        end
        repeat (2) @(negedge clk);
        chk("arb_end_idle", busy, 0);

        // Silent engine on the 16-cycle instance.
        we0 = 1'b1; addr0 = 11'h321; wdata0 = 8'h77; reqb0 = 1'b1;
        for (k = 0; k < 8; k++) begin
            @(negedge clk);
            if (e_wr_b) break;
        end
        chk("to_cmd_lat", k, 0);
        bad = 0;
        for (n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (doneb0 | doneb1) bad++;
            if (errb0) break;
        end
        chk("to_err_lat", n, 17);
        chk("to_e_reset", e_reset_b, 1);
        chk("to_err1", errb1, 0);
        chk("to_no_done", bad, 0);
        reqb0 = 1'b0;
        @(negedge clk);
        chk("to_pulse_once", {errb0, e_reset_b, busy_b}, 3'b000);
        addr0 = 11'h0AB; reqb0 = 1'b1;
        for (k = 0; k < 8; k++) begin
            @(negedge clk);
            if (e_wr_b) break;
        end
        chk("to_next_cmd", k, 0);
        chk("to_next_addr", e_addr_b, 11'h0AB);
        repeat (2) @(negedge clk);
        ackb = 1'b1;
        @(negedge clk);
        ackb = 1'b0;
        chk("to_next_done", {errb0, doneb0}, 2'b01);
        reqb0 = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
